construct_data: RTL and testbench

- Write-side packer: accepts a stream of narrow OSIZE-bit pixels and packs them into ISIZE-bit memory words for the write channel.
- It is the inverse of the read-side unpacker, so the two must be bit-exact inverses.
- Pixels are packed as a continuous bit stream. Pixel 0 occupies the MSBs of word 0.
- A pixel that straddles a word boundary is split: its upper bits fill the LSBs of the current word, and its remaining lower bits start the MSBs of the next word.
- Flush closes a partial word, with a byte mask, at end of line or end of frame.

---
 rtl/construct_data_if.sv | 32 +++
 rtl/construct_data.sv | 144 ++++++++++++++
 tb/tb_construct_data.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/construct_data_if.sv
`default_nettype none
// ============================================================================
// Module   : construct_data_if
// Desc     : Pixel-in / packed-word-out handshake bundle for construct_data.
// Revision : 1.0  initial release
// ============================================================================
interface construct_data_if #(
  parameter int ISIZE = 256,
  parameter int OSIZE = 24
);
  logic               ialign;
  logic               iflush;
  logic               ivalid;
  logic               iready;
  logic [OSIZE-1:0]   idata;
  logic               ovalid;
  logic               oready;
  logic [ISIZE-1:0]   odata;
  logic [ISIZE/8-1:0] omask;
  logic               olast;

  modport master (
    output ialign, iflush, ivalid, idata, oready,
    input  iready, ovalid, odata, omask, olast
  );

  modport slave (
    input  ialign, iflush, ivalid, idata, oready,
    output iready, ovalid, odata, omask, olast
  );
endinterface
`default_nettype wire

// File: rtl/construct_data.sv
`default_nettype none
// ============================================================================
// Module   : construct_data
// Desc     : Write-side packer: OSIZE-bit pixels -> ISIZE-bit words, MSB first,
//            with masked flush of partial words. Optional CONSTRUCT_WORD_CNT_EN
//            adds the owcnt handed-off word counter.
// Revision : 1.0  initial release
// ============================================================================
module construct_data #(
  parameter int ISIZE = 256,
  parameter int OSIZE = 24
) (
  input  logic            clock,
  input  logic            rst_n,
  construct_data_if.slave bus
`ifdef CONSTRUCT_WORD_CNT_EN
  ,
  output logic [15:0]     owcnt
`endif
);

  localparam int              c_AW        = ISIZE + OSIZE;
  localparam int              c_FW        = $clog2(ISIZE) + 1;
  localparam int              c_MW        = ISIZE / 8;
  localparam logic [c_FW-1:0] c_ISIZE_F   = c_FW'(ISIZE);
  localparam logic [c_FW-1:0] c_OSIZE_F   = c_FW'(OSIZE);
  localparam logic [c_MW-1:0] c_MASK_ONES = '1;

  logic [c_AW-1:0]  r_acc,        w_acc_n;
  logic [c_FW-1:0]  r_fill,       w_fill_n;
  logic             r_flush_pend, w_flush_pend_n;
  logic             r_ovalid,     w_ovalid_n;
  logic [ISIZE-1:0] r_odata,      w_odata_n;
  logic [c_MW-1:0]  r_omask,      w_omask_n;
  logic             r_olast,      w_olast_n;

  logic             w_full;
  logic             w_ready;
  logic             w_accept;
  logic             w_flush_req;
  logic             w_word_done;
  logic [c_AW-1:0]  w_pix_ext;
  logic [c_AW-1:0]  w_acc_app;
  logic [c_AW-1:0]  w_acc_cur;
  logic [c_FW-1:0]  w_fill_app;
  logic [c_FW-1:0]  w_fill_cur;
  logic [c_FW-1:0]  w_nbytes;

  assign w_full      = r_ovalid && !bus.oready;
  assign w_ready     = !w_full && !r_flush_pend && !bus.ialign;
  assign w_accept    = bus.ivalid && w_ready;
  assign w_flush_req = bus.iflush || r_flush_pend;

  // acc is MSB-aligned: valid bits sit at the top, the new pixel lands just below them
  assign w_pix_ext   = {{ISIZE{1'b0}}, bus.idata};
  assign w_acc_app   = r_acc | (w_pix_ext << (c_ISIZE_F - r_fill));
  assign w_fill_app  = r_fill + c_OSIZE_F;
  assign w_word_done = w_accept && (w_fill_app >= c_ISIZE_F);
  assign w_acc_cur   = w_accept ? w_acc_app  : r_acc;
  assign w_fill_cur  = w_accept ? w_fill_app : r_fill;
  assign w_nbytes    = (w_fill_cur + c_FW'(7)) >> 3;

  always_comb begin
    w_acc_n        = w_acc_cur;
    w_fill_n       = w_fill_cur;
    w_flush_pend_n = r_flush_pend;
    w_ovalid_n     = r_ovalid && !bus.oready;
    w_odata_n      = r_odata;
    w_omask_n      = r_omask;
    w_olast_n      = r_olast;

    if (bus.ialign) begin
      w_acc_n        = '0;
      w_fill_n       = '0;
      w_flush_pend_n = 1'b0;
      w_ovalid_n     = 1'b0;
    end else if (w_word_done) begin
      w_odata_n      = w_acc_app[c_AW-1 -: ISIZE];
      w_omask_n      = c_MASK_ONES;
      w_olast_n      = 1'b0;
      w_ovalid_n     = 1'b1;
      w_acc_n        = w_acc_app << ISIZE;
      w_fill_n       = w_fill_app - c_ISIZE_F;
      // the residual cannot share this cycle's output slot, so defer its flush
      w_flush_pend_n = bus.iflush;
    end else if (w_flush_req && !w_full) begin
      if (w_fill_cur != '0) begin
        w_odata_n  = w_acc_cur[c_AW-1 -: ISIZE];
        w_omask_n  = ~(c_MASK_ONES >> w_nbytes);
        w_olast_n  = 1'b1;
        w_ovalid_n = 1'b1;
      end
      w_acc_n        = '0;
      w_fill_n       = '0;
      w_flush_pend_n = 1'b0;
    end else if (w_flush_req) begin
      w_flush_pend_n = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_fill       <= '0;
      r_flush_pend <= 1'b0;
      r_ovalid     <= 1'b0;
      r_odata      <= '0;
      r_omask      <= '0;
      r_olast      <= 1'b0;
    end else begin
      r_acc        <= w_acc_n;
      r_fill       <= w_fill_n;
      r_flush_pend <= w_flush_pend_n;
      r_ovalid     <= w_ovalid_n;
      r_odata      <= w_odata_n;
      r_omask      <= w_omask_n;
      r_olast      <= w_olast_n;
    end
  end

  assign bus.iready = w_ready;
  assign bus.ovalid = r_ovalid;
  assign bus.odata  = r_odata;
  assign bus.omask  = r_omask;
  assign bus.olast  = r_olast;

`ifdef CONSTRUCT_WORD_CNT_EN
  logic [15:0] r_owcnt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_owcnt <= '0;
    end else if (bus.ialign) begin
      r_owcnt <= '0;
    end else if (r_ovalid && bus.oready) begin
      r_owcnt <= r_owcnt + 16'd1;
    end
  end

  assign owcnt = r_owcnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_construct_data.sv
`default_nettype none
// ============================================================================
// Module   : tb_construct_data
// Desc     : Bit-stream reference model + scoreboard bench for construct_data.
// Revision : 1.0  initial release
// ============================================================================
module tb_construct_data;
  localparam int ISIZE = 256;
  localparam int OSIZE = 24;
  localparam int MW    = ISIZE / 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  construct_data_if #(.ISIZE(ISIZE), .OSIZE(OSIZE)) bus ();
`ifdef CONSTRUCT_WORD_CNT_EN
  logic [15:0] owcnt;
`endif

  construct_data #(.ISIZE(ISIZE), .OSIZE(OSIZE)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CONSTRUCT_WORD_CNT_EN
    ,
    .owcnt (owcnt)
`endif
  );

  typedef struct packed {
    logic [ISIZE-1:0] data;
    logic [MW-1:0]    mask;
    logic             last;
  } word_t;

  word_t       expq[$];
  bit          bits[$];
  bit          pend;
  logic [15:0] wcnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [ISIZE-1:0] act, input logic [ISIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops up to one word of the pending bit stream, MSB first, zero padded
  task automatic emit(input bit last);
    word_t w;
    int    n;
    w      = '0;
    w.last = last;
    n      = (bits.size() > ISIZE) ? ISIZE : bits.size();
    for (int i = 0; i < n; i++) w.data[ISIZE-1-i] = bits.pop_front();
    for (int b = 0; b < (n + 7) / 8; b++) w.mask[MW-1-b] = 1'b1;
    expq.push_back(w);
  endtask

  // Reference model: evaluated before each rising edge with that edge's inputs
  always @(negedge clock) begin : model
    bit full;
    bit exp_rdy;
    bit acc;
    if (!rst_n) begin
      bits.delete();
      expq.delete();
      pend = 1'b0;
      wcnt = '0;
    end else begin
`ifdef CONSTRUCT_WORD_CNT_EN
      check("owcnt", ISIZE'(owcnt), ISIZE'(wcnt));
`endif
      full    = bus.ovalid && !bus.oready;
      exp_rdy = !bus.ialign && !pend && !full;
      check("iready", ISIZE'(bus.iready), ISIZE'(exp_rdy));
      if (bus.ialign) begin
        bits.delete();
        expq.delete();
        pend = 1'b0;
        wcnt = '0;
      end else begin
        acc = bus.ivalid && exp_rdy;
        if (bus.ovalid && bus.oready) wcnt++;
        if (acc) for (int i = OSIZE - 1; i >= 0; i--) bits.push_back(bus.idata[i]);
        if (acc && bits.size() >= ISIZE) begin
          emit(1'b0);
          pend = bus.iflush;
        end else if ((bus.iflush || pend) && !full) begin
          if (bits.size() > 0) emit(1'b1);
          pend = 1'b0;
        end else if (bus.iflush) begin
          pend = 1'b1;
        end
      end
    end
  end

  logic [ISIZE-1:0] held_data;
  logic [MW-1:0]    held_mask;
  logic             held_last;
  bit               held = 1'b0;

  always @(negedge clock) begin : monitor
    word_t w;
    if (!rst_n || bus.ialign) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", ISIZE'(bus.ovalid), ISIZE'(1'b1));
        check("hold_data", bus.odata, held_data);
        check("hold_mask", ISIZE'(bus.omask), ISIZE'(held_mask));
        check("hold_last", ISIZE'(bus.olast), ISIZE'(held_last));
      end
      if (bus.ovalid && bus.oready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected no word", bus.odata);
        end else begin
          w = expq.pop_front();
          check("odata", bus.odata, w.data);
          check("omask", ISIZE'(bus.omask), ISIZE'(w.mask));
          check("olast", ISIZE'(bus.olast), ISIZE'(w.last));
        end
      end
      held      = bus.ovalid && !bus.oready;
      held_data = bus.odata;
      held_mask = bus.omask;
      held_last = bus.olast;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pixel(input logic [OSIZE-1:0] d, input logic fl);
    bit done;
    done       = 1'b0;
    bus.ivalid = 1'b1;
    bus.idata  = d;
    bus.iflush = fl;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clock);
      done = bus.iready;
      step();
      bus.iflush = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got iready=0 for 200 cycles expected acceptance");
    end
  endtask

  task automatic align();
    bus.ialign = 1'b1;
    step();
    bus.ialign = 1'b0;
  endtask

  task automatic flush();
    bus.iflush = 1'b1;
    step();
    bus.iflush = 1'b0;
  endtask

  initial begin
    bus.ialign = 1'b0;
    bus.iflush = 1'b0;
    bus.ivalid = 1'b0;
    bus.idata  = '0;
    bus.oready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_ovalid", ISIZE'(bus.ovalid), '0);
    check("rst_odata", bus.odata, '0);
    check("rst_omask", ISIZE'(bus.omask), '0);
    check("rst_olast", ISIZE'(bus.olast), '0);
    step();
    rst_n = 1'b1;
    step();

    // 11 pixels -> one full word one cycle after the last accept
    for (int k = 0; k < 11; k++) send_pixel(OSIZE'(24'hA00000 + k), 1'b0);
    bus.ivalid = 1'b0;
    @(negedge clock);
    check("t1_latency", ISIZE'(bus.ovalid), ISIZE'(1'b1));
    step();

    // 32 pixels -> three words, nothing left for the flush
    align();
    for (int k = 0; k < 32; k++) send_pixel(OSIZE'(24'hA00000 + k), 1'b0);
    bus.ivalid = 1'b0;
    repeat (4) step();
    flush();
    repeat (3) step();

    // 3 pixels then flush
    for (int k = 0; k < 3; k++) send_pixel(OSIZE'(24'hA00000 + k), 1'b0);
    bus.ivalid = 1'b0;
    flush();
    repeat (3) step();

    // back-pressure on the first word
    align();
    bus.oready = 1'b0;
    for (int k = 0; k < 11; k++) send_pixel(OSIZE'(24'hA00000 + k), 1'b0);
    bus.idata = OSIZE'(24'hA0000B);
    repeat (6) step();
    bus.oready = 1'b1;
    for (int k = 11; k < 22; k++) send_pixel(OSIZE'(24'hA00000 + k), 1'b0);
    bus.ivalid = 1'b0;
    flush();
    repeat (3) step();

    // ialign with a pending word, then with a partial fill of 120 bits
    align();
    bus.oready = 1'b0;
    for (int k = 0; k < 11; k++) send_pixel(OSIZE'(24'hB00000 + k), 1'b0);
    bus.ivalid = 1'b0;
    align();
    @(negedge clock);
    check("t5_ovalid_drop", ISIZE'(bus.ovalid), '0);
    bus.oready = 1'b1;
    step();
    for (int k = 0; k < 5; k++) send_pixel(OSIZE'(24'hC00000 + k), 1'b0);
    bus.ivalid = 1'b0;
    align();
    for (int k = 0; k < 11; k++) send_pixel(OSIZE'(24'hA00000 + k), 1'b0);
    bus.ivalid = 1'b0;
    repeat (3) step();

    // flush together with the word-completing pixel
    align();
    for (int k = 0; k < 10; k++) send_pixel(OSIZE'(24'hA00000 + k), 1'b0);
    send_pixel(OSIZE'(24'hA0000A), 1'b1);
    bus.ivalid = 1'b0;
    @(negedge clock);
    check("t6_iready_gap", ISIZE'(bus.iready), '0);
    repeat (4) step();

    // asynchronous reset mid-word discards the partial fill
    for (int k = 0; k < 4; k++) send_pixel(OSIZE'(24'hD00000 + k), 1'b0);
    bus.ivalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clock);
    check("mid_rst_ovalid", ISIZE'(bus.ovalid), '0);
    step();
    rst_n = 1'b1;
    step();
    flush();
    repeat (3) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.ivalid = ($urandom_range(0, 9) < 7);
      bus.idata  = OSIZE'($urandom);
      bus.iflush = ($urandom_range(0, 19) == 0);
      bus.ialign = ($urandom_range(0, 149) == 0);
      bus.oready = ($urandom_range(0, 9) < 7);
      step();
    end

    bus.ivalid = 1'b0;
    bus.iflush = 1'b0;
    bus.ialign = 1'b0;
    bus.oready = 1'b1;
    repeat (3) step();
    flush();
    repeat (10) step();
    check("drain_empty", ISIZE'(expq.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
